// File: rtl/alu_seq_if.sv
// Request/result bundle between the register-read stage and the sequential ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the driver of valid must hold valid and its payload stable until that edge.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [4:0]       ALUOp;
  logic             SetFlags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             ResultWr;
  logic [3:0]       ALUFlags;
  logic             busy;

  modport master (
    output in_valid, SrcA, SrcB, ALUOp, SetFlags, out_ready,
    input  in_ready, out_valid, ALUResult, ResultWr, ALUFlags, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUOp, SetFlags, out_ready,
    output in_ready, out_valid, ALUResult, ResultWr, ALUFlags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flag register and an iterative shift-add multiply.
// One operation in flight at a time: IDLE accepts, BUSY multiplies, DONE presents the result.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus,
  output logic [1:0] fsm_state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] res_q, acc_q, mcand_q, mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       flags_q;
  logic             wr_q, mul_s_q;

  logic             is_mul;
  logic [3:0]       op;
  logic [WIDTH-1:0] x, y, logic_res, alu_res, mul_acc_next;
  logic             cin, arith, cmp_op, alu_upd, alu_c, alu_v;
  logic [WIDTH:0]   sum;

  assign is_mul = MUL_EN && bus.ALUOp[4];

  // Single-cycle datapath works straight off the request so the result lands on the accept edge.
  always_comb begin
    op        = bus.ALUOp[3:0];
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    arith     = 1'b0;
    logic_res = '0;
    if (!MUL_EN && bus.ALUOp[4]) op = 4'b1101;
    case (op)
      4'h0, 4'h8: logic_res = bus.SrcA & bus.SrcB;
      4'h1, 4'h9: logic_res = bus.SrcA ^ bus.SrcB;
      4'h2, 4'hA: begin x = bus.SrcA; y = ~bus.SrcB; cin = 1'b1;       arith = 1'b1; end
      4'h3:       begin x = bus.SrcB; y = ~bus.SrcA; cin = 1'b1;       arith = 1'b1; end
      4'h4, 4'hB: begin x = bus.SrcA; y = bus.SrcB;  cin = 1'b0;       arith = 1'b1; end
      4'h5:       begin x = bus.SrcA; y = bus.SrcB;  cin = flags_q[1]; arith = 1'b1; end
      4'h6:       begin x = bus.SrcA; y = ~bus.SrcB; cin = flags_q[1]; arith = 1'b1; end
      4'h7:       begin x = bus.SrcB; y = ~bus.SrcA; cin = flags_q[1]; arith = 1'b1; end
      4'hC:       logic_res = bus.SrcA | bus.SrcB;
      4'hD:       logic_res = bus.SrcB;
      4'hE:       logic_res = bus.SrcA & ~bus.SrcB;
      default:    logic_res = ~bus.SrcB;
    endcase
    sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    alu_res = arith ? sum[WIDTH-1:0] : logic_res;
    alu_c   = sum[WIDTH];
    alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    cmp_op  = (op[3:2] == 2'b10);
    alu_upd = bus.SetFlags || cmp_op;
  end

  assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = is_mul ? BUSY : DONE;
      BUSY:    if (cnt_q == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      flags_q  <= 4'b0000;
      wr_q     <= 1'b0;
      mul_s_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_mul) begin
              mcand_q  <= bus.SrcA;
              mplier_q <= bus.SrcB;
              acc_q    <= '0;
              cnt_q    <= '0;
              mul_s_q  <= bus.SetFlags;
            end else begin
              res_q <= alu_res;
              wr_q  <= !cmp_op;
              if (alu_upd)
                flags_q <= {alu_res[WIDTH-1], (alu_res == '0),
                            arith ? alu_c : flags_q[1], arith ? alu_v : flags_q[0]};
            end
          end
        end
        BUSY: begin
          acc_q    <= mul_acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            res_q <= mul_acc_next;
            wr_q  <= 1'b1;
            // Multiply only touches N and Z; C and V carry through.
            if (mul_s_q) flags_q[3:2] <= {mul_acc_next[WIDTH-1], (mul_acc_next == '0)};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && reset_n;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);
  assign bus.ALUResult = res_q;
  assign bus.ResultWr  = wr_q;
  assign bus.ALUFlags  = flags_q;
  assign fsm_state     = state;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Accepts one operation at a time through a valid/ready handshake.
- Supports the full 4-bit data-processing opcode set plus an iterative multiply, and keeps an architectural NZCV flag register that ADC/SBC consume.
- Sits between the register-read stage and writeback; the condition-check logic reads its flags output.

Parameters:
- WIDTH, 32: operand/result width in bits (>= 4).
- MUL_EN, 1: 1 = multiply supported; 0 = MUL executes as MOV (result = SrcB).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- SrcA  input  WIDTH  first operand.
- SrcB  input  WIDTH  second operand.
- ALUOp  input  5  [4] = MUL, [3:0] = data-processing opcode.
- SetFlags  input  1  S bit; update NZCV on completion.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  WIDTH  registered result.
- ResultWr  output  1  result is to be written back (0 for TST/TEQ/CMP/CMN).
- ALUFlags  output  4  registered NZCV, bit3 = N … bit0 = V.
- busy  output  1  multiply in progress.

Behaviour:
- Reset: one clock with reset_n = 0 on a rising edge. Effects:
  - state = IDLE
  - in_ready = 0 during reset, then 1
  - out_valid = 0, ALUResult = 0, ResultWr = 0, ALUFlags = 4'b0000, busy = 0
- Reset mid-operation aborts: any multiply or pending result is discarded, with no flag update.
- States:
  - IDLE: in_ready = 1. On in_valid, capture operands/op. If ALUOp[4] = 1 and MUL_EN = 1, go to BUSY; otherwise compute and go to DONE.
  - BUSY: shift-add multiply, one bit per cycle, WIDTH cycles. Then go to DONE.
  - DONE: out_valid = 1 and outputs held stable. On out_ready, go to IDLE.
- Latency from the accept edge to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MUL.
- Throughput:
  - 1 op per 2 cycles; in_ready is low in BUSY/DONE, so there is no overlap.
  - in_valid while in_ready = 0 is ignored, and the request must be held by the requester.
- Opcodes ([3:0]):
  - 0000 AND, 0001 EOR, 0010 SUB (A-B), 0011 RSB (B-A)
  - 0100 ADD, 0101 ADC (A+B+C), 0110 SBC (A-B-!C), 0111 RSC (B-A-!C)
  - 1000 TST (AND), 1001 TEQ (EOR), 1010 CMP (SUB), 1011 CMN (ADD)
  - 1100 ORR, 1101 MOV (B), 1110 BIC (A&~B), 1111 MVN (~B)
- MUL result = low WIDTH bits of A*B, unsigned. ALUOp[3:0] is ignored when ALUOp[4] = 1.
- Arithmetic is done at WIDTH+1 bits for the carry:
  - Subtraction is computed as X + ~Y + 1, or + C for SBC/RSC.
  - C = carry out, i.e. ARM not-borrow for subtraction.
  - V = signed overflow of the operands actually added.
- Flag update happens on the edge entering DONE, and only when SetFlags = 1 or the op is TST/TEQ/CMP/CMN:
  - N = result[WIDTH-1]; Z = (result == 0).
  - C, V updated for arithmetic ops (0010–0111, 1010, 1011).
  - C, V preserved for logical ops, MOV, MVN and MUL.
- Without an update, ALUFlags is unchanged.
- ADC/SBC/RSC read the C bit of the ALUFlags register at the accept edge.
- ResultWr = 0 for 1000–1011 (ALUResult still carries the computed value); 1 otherwise.
- Flags become visible in the same cycle out_valid rises.
- in_valid and out_ready both high in DONE: the result is consumed and the next op is accepted no earlier than the following cycle, in IDLE.
- No X is ever driven on any output. This is a deliberate change from the old don't-care flag bits.

Test Plan:
- WIDTH=32, reset_n=0 for 1 cycle, then 1 → in_ready=1, out_valid=0, ALUFlags=0000, ALUResult=0.
- ADD, S=1, A=32'h7FFFFFFF, B=1 → out_valid after 1 cycle; ALUResult=32'h80000000, NZCV=1001, ResultWr=1.
- CMP, S=0, A=5, B=5 → ALUResult=0, ResultWr=0, NZCV=0110. Then SBC S=1 A=10 B=3 → ALUResult=7, NZCV=0010.
- MUL, A=32'h0001_0003, B=32'h0000_0010, S=1 with prior NZCV=0011 → busy for 32 cycles, out_valid on cycle 33, ALUResult=32'h0010_0030, NZCV=0011.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands → result and flags stable, in_ready=0, new request not accepted until the cycle after out_ready.
- Start a MUL, assert reset_n=0 at busy cycle 10 → next cycle: out_valid=0, busy=0, ALUFlags=0000, in_ready=1 after release.
